sd_sector_cache: RTL and testbench
==================================

// Module: sd_sector_cache
// PURPOSE
//  Single-sector write-back cache between the mist_io SD block interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*)
//  and the Einstein floppy controller's byte port. The FDC requests a 512-byte sector by LBA and then reads or
//  writes bytes locally; the block fetches from the host on miss and writes back dirty data before eviction.
//  It sits directly downstream of mist_io and upstream of the tatung FDC. It serves disk 0 only.
// PARAMETERS
//  TIMEOUT_W  24  width of the sd_ack watchdog; the handshake aborts after 2**TIMEOUT_W-1 cycles without ack
// PORTS
//  clk_sys       in   1   system clock (32 MHz); sole clock
//  reset         in   1   synchronous, active-high reset
//  img_mounted   in   1   one-cycle pulse: new image on disk 0
//  img_size      in   32  image size in bytes, sampled when img_mounted is high
//  req_lba       in   32  sector index requested by the FDC
//  req_load      in   1   pulse: make sector req_lba resident
//  req_flush     in   1   pulse: write back the resident sector if dirty
//  busy          out  1   high from the accepted request until completion
//  done          out  1   one-cycle pulse on completion, success or error
//  err           out  1   held with done: out of range, no image, or timeout
//  cpu_addr      in   9   byte offset within the resident sector
//  cpu_we        in   1   byte write strobe
//  cpu_wdata     in   8   byte write data
//  cpu_rdata     out  8   byte read data, 1-cycle latency
//  sd_lba        out  32  LBA to mist_io
//  sd_rd         out  1   read request to mist_io
//  sd_wr         out  1   write request to mist_io
//  sd_ack        in   1   host acknowledge; high for the whole transfer
//  sd_buff_addr  in   9   host buffer byte address
//  sd_buff_dout  in   8   host-to-core data
//  sd_buff_wr    in   1   host-to-core write strobe
//  sd_buff_din   out  8   core-to-host data, registered RAM[sd_buff_addr], 1-cycle latency
// BEHAVIOUR
//  - Reset values: all outputs 0. Internally valid=0, dirty=0, cached_lba=0, sectors=0, state=IDLE.
//  - img_mounted: set sectors=img_size>>9 and clear valid and dirty (pending data is discarded). In a non-IDLE
//    state the block aborts to IDLE with done=1 and err=1; the host handshake is abandoned.
//  - FSM states: IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER, FINISH.
//  - IDLE + req_load:
//    - req_lba>=sectors -> FINISH with err.
//    - valid && req_lba==cached_lba -> FINISH (hit; done 2 cycles after req_load).
//    - dirty -> WB_REQ.
//    - otherwise -> RD_REQ.
//    - busy=1 from the next cycle onward.
//  - IDLE + req_flush: dirty -> WB_REQ; otherwise -> FINISH with no error.
//  - If req_load and req_flush arrive in the same cycle, req_load wins. Requests while busy are ignored.
//  - WB_REQ: sd_lba=cached_lba and sd_wr=1 until sd_ack rises; then -> WB_XFER with sd_wr=0. WB_XFER ends on the
//    sd_ack falling edge: dirty=0, then -> RD_REQ if a load is pending, else -> FINISH.
//  - RD_REQ and RD_XFER behave the same way with sd_rd and sd_lba=req_lba, where req_lba is latched at accept.
//    In RD_XFER, sd_buff_wr writes sd_buff_dout into RAM[sd_buff_addr]. On the sd_ack fall: cached_lba=latched
//    LBA, valid=1, dirty=0.
//  - Watchdog: in any *_REQ or *_XFER state the counter resets on every sd_ack edge and saturates. At all-ones:
//    drop sd_rd/sd_wr, valid=0, FINISH with err. The dirty flag is kept on a write-back timeout.
//  - FINISH: done=1 and err as decided for one cycle, busy=0 in the same cycle, then -> IDLE.
//  - CPU port: cpu_rdata=RAM[cpu_addr], registered. cpu_we is honoured only when state==IDLE && valid, and it
//    sets dirty. A write accepted in the same cycle as req_load or req_flush is applied first, so the
//    write-back includes it.
//  - Sector RAM: true dual-port 512x8. Port A is the CPU side, port B the host side. No same-address
//    arbitration is needed, because the CPU can write only in IDLE.
// STRUCTURE
//  - Package einstein_disk_pkg: SECTOR_BYTES=512, SECTOR_SHIFT=9, and the state enum cache_state_t.
//  - Sub-module sector_dpram: 512x8 dual-port synchronous RAM with registered reads on both ports.
//  - The FSM, watchdog and flags stay in sd_sector_cache.
// TESTING
//  - Mount with img_size=0x2D000 (360 sectors), then req_load lba=5: sd_rd rises with sd_lba=5. The host model
//    acks and writes 512 bytes 0x00..0xFF repeating. Then done=1, err=0, and cpu_addr=0x101 -> cpu_rdata=0x01.
//  - Repeat req_load lba=5: no sd_rd, done pulses 2 cycles after the request.
//  - Write cpu_addr=3 data 0xA5, then req_load lba=7: first sd_wr with sd_lba=5. The host reads
//    sd_buff_addr=3 -> 0xA5. After that sd_rd with sd_lba=7 follows.
//  - req_load lba=360: done=1, err=1, sd_rd/sd_wr stay 0. Unmounted (sectors=0), lba=0: err=1.
//  - Host never acks: after 2**TIMEOUT_W-1 cycles sd_rd drops and done=1, err=1. With TIMEOUT_W=8 the timeout
//    is 255 cycles.
//  - img_mounted pulse mid RD_XFER: done=1, err=1, then IDLE. A following cpu_we is ignored (valid=0).

Source files
------------

// File: rtl/einstein_disk_pkg.sv
// Purpose: shared constants and FSM state type for the Einstein disk sector cache.
// Latency: n/a (package only).
// Backpressure: n/a.
package einstein_disk_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_XFER,
    ST_RD_REQ,
    ST_RD_XFER,
    ST_FINISH
  } cache_state_t;

endpackage

// File: rtl/sector_dpram.sv
// Purpose: 512x8 true dual-port sector RAM; port A = CPU side, port B = host side.
// Latency: 1 cycle registered read on both ports (read-before-write on the same port).
// Backpressure: none; accepts an access on each port every cycle.
// Ports: i_clk/i_rst clock and sync reset (clears only the read registers),
//        i_a_* / o_a_rdata CPU port, i_b_* / o_b_rdata host port.
module sector_dpram
  import einstein_disk_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_a_we,
  input  logic [SECTOR_SHIFT-1:0] i_a_addr,
  input  logic [7:0]              i_a_wdata,
  output logic [7:0]              o_a_rdata,
  input  logic                    i_b_we,
  input  logic [SECTOR_SHIFT-1:0] i_b_addr,
  input  logic [7:0]              i_b_wdata,
  output logic [7:0]              o_b_rdata
);

  logic [7:0] r_mem [0:SECTOR_BYTES-1];
  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;

  // Storage array carries no reset; only the read registers do.
  always_ff @(posedge i_clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_rdata <= 8'd0;
      r_b_rdata <= 8'd0;
    end else begin
      r_a_rdata <= r_mem[i_a_addr];
      r_b_rdata <= r_mem[i_b_addr];
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/sd_sector_cache.sv
// Purpose: single-sector write-back cache between mist_io SD block port and the FDC byte port.
// Latency: hit done 2 cycles after req_load; cpu_rdata / sd_buff_din 1 cycle after address.
// Backpressure: requests while busy are dropped; host handshake guarded by an sd_ack watchdog.
// Ports: img_* mount info; req_*/busy/done/err request handshake; cpu_* FDC byte port;
//        sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* mist_io block interface.
module sd_sector_cache
  import einstein_disk_pkg::*;
#(
  parameter int TIMEOUT_W = 24
)
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic [31:0] req_lba,
  input  logic        req_load,
  input  logic        req_flush,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [8:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  cache_state_t r_state, w_state_nxt;

  logic                 r_valid, r_dirty, r_load_pend, r_err;
  logic [31:0]          r_cached_lba, r_req_lba, r_sectors;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_ack_d;
  logic                 r_busy, r_done, r_err_o;

  logic w_ack_rise, w_ack_fall, w_wd_max, w_active;
  logic w_cpu_wr, w_dirty_eff;
  logic w_accept_load, w_accept_flush, w_range_err;
  logic w_wb_done, w_rd_done, w_timeout;
  logic w_unused;

  assign w_unused   = ^img_size[SECTOR_SHIFT-1:0];
  assign w_ack_rise = sd_ack & ~r_ack_d;
  assign w_ack_fall = ~sd_ack & r_ack_d;
  assign w_wd_max   = &r_wd;
  assign w_active   = (r_state == ST_WB_REQ) || (r_state == ST_WB_XFER) ||
                      (r_state == ST_RD_REQ) || (r_state == ST_RD_XFER);

  // A CPU write in the request cycle counts towards the dirty decision,
  // so the write-back carries it.
  assign w_cpu_wr    = cpu_we && (r_state == ST_IDLE) && r_valid && !img_mounted;
  assign w_dirty_eff = r_dirty | w_cpu_wr;

  always_comb begin
    w_state_nxt    = r_state;
    w_accept_load  = 1'b0;
    w_accept_flush = 1'b0;
    w_range_err    = 1'b0;
    w_wb_done      = 1'b0;
    w_rd_done      = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A mount in the same cycle takes precedence over any request.
        if (!img_mounted) begin
          if (req_load) begin
            w_accept_load = 1'b1;
            if (req_lba >= r_sectors) begin
              w_range_err = 1'b1;
              w_state_nxt = ST_FINISH;
            end else if (r_valid && (req_lba == r_cached_lba)) begin
              w_state_nxt = ST_FINISH;
            end else if (w_dirty_eff) begin
              w_state_nxt = ST_WB_REQ;
            end else begin
              w_state_nxt = ST_RD_REQ;
            end
          end else if (req_flush) begin
            w_accept_flush = 1'b1;
            w_state_nxt    = w_dirty_eff ? ST_WB_REQ : ST_FINISH;
          end
        end
      end
      ST_WB_REQ, ST_RD_REQ: begin
        if (w_wd_max) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (w_ack_rise) begin
          w_state_nxt = (r_state == ST_WB_REQ) ? ST_WB_XFER : ST_RD_XFER;
        end
      end
      ST_WB_XFER: begin
        if (w_wd_max) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (w_ack_fall) begin
          w_wb_done   = 1'b1;
          w_state_nxt = r_load_pend ? ST_RD_REQ : ST_FINISH;
        end
      end
      ST_RD_XFER: begin
        if (w_wd_max) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (w_ack_fall) begin
          w_rd_done   = 1'b1;
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_dirty      <= 1'b0;
      r_load_pend  <= 1'b0;
      r_err        <= 1'b0;
      r_cached_lba <= 32'd0;
      r_req_lba    <= 32'd0;
      r_sectors    <= 32'd0;
      r_wd         <= '0;
      r_ack_d      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_o      <= 1'b0;
    end else begin
      r_ack_d <= sd_ack;
      r_state <= w_state_nxt;
      // busy covers the FINISH cycle; done/err are issued on leaving FINISH,
      // which is also the first cycle with busy low.
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_FINISH);
      r_err_o <= (r_state == ST_FINISH) && r_err;

      // Watchdog restarts on every sd_ack edge and saturates at all-ones.
      if (!w_active || w_ack_rise || w_ack_fall) r_wd <= '0;
      else if (!w_wd_max)                        r_wd <= r_wd + TIMEOUT_W'(1);

      if (w_accept_load || w_accept_flush) begin
        r_err       <= w_range_err;
        r_load_pend <= w_accept_load;
      end
      if (w_accept_load) r_req_lba <= req_lba;
      if (w_cpu_wr)      r_dirty   <= 1'b1;
      if (w_wb_done)     r_dirty   <= 1'b0;
      if (w_rd_done) begin
        r_dirty      <= 1'b0;
        r_valid      <= 1'b1;
        r_cached_lba <= r_req_lba;
      end
      // Dirty is deliberately kept on timeout so a failed write-back can be retried.
      if (w_timeout) begin
        r_valid <= 1'b0;
        r_err   <= 1'b1;
      end

      if (img_mounted) begin
        r_sectors <= {{SECTOR_SHIFT{1'b0}}, img_size[31:SECTOR_SHIFT]};
        r_valid   <= 1'b0;
        r_dirty   <= 1'b0;
        if (r_state != ST_IDLE) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err_o <= 1'b1;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err_o;
  assign sd_rd  = (r_state == ST_RD_REQ);
  assign sd_wr  = (r_state == ST_WB_REQ);
  assign sd_lba = ((r_state == ST_WB_REQ) || (r_state == ST_WB_XFER)) ? r_cached_lba : r_req_lba;

  sector_dpram u_ram (
    .i_clk     (clk_sys),
    .i_rst     (reset),
    .i_a_we    (w_cpu_wr),
    .i_a_addr  (cpu_addr),
    .i_a_wdata (cpu_wdata),
    .o_a_rdata (cpu_rdata),
    .i_b_we    (sd_buff_wr && (r_state == ST_RD_XFER)),
    .i_b_addr  (sd_buff_addr),
    .i_b_wdata (sd_buff_dout),
    .o_b_rdata (sd_buff_din)
  );

endmodule

// File: tb/tb_sd_sector_cache.sv
// Purpose: self-checking bench for sd_sector_cache with a host disk model and RAM/flag model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_sector_cache;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        img_mounted = 1'b0;
  logic [31:0] img_size = 32'd0;
  logic [31:0] req_lba = 32'd0;
  logic        req_load = 1'b0, req_flush = 1'b0;
  logic        busy, done, err;
  logic [8:0]  cpu_addr = 9'd0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = 9'd0;
  logic [7:0]  sd_buff_dout = 8'd0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;

  sd_sector_cache #(.TIMEOUT_W(10)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .req_lba(req_lba), .req_load(req_load), .req_flush(req_flush),
    .busy(busy), .done(done), .err(err),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Host-side disk image and cache model.
  logic [7:0]  disk [0:359][0:511];
  logic [7:0]  m_mem [0:511];
  bit          m_known [0:511];
  bit          m_valid = 0, m_dirty = 0, m_idle = 1, m_rdx = 0;
  logic [31:0] m_lba = 32'd0, m_sectors = 32'd0;
  bit          cmp_en = 0;
  bit          k_rd = 0, k_din = 0;
  logic [7:0]  e_rd = 8'd0, e_din = 8'd0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM model: reads see the contents before this edge's writes.
  always @(posedge clk_sys) begin
    k_rd  <= m_known[cpu_addr];
    e_rd  <= m_mem[cpu_addr];
    k_din <= m_known[sd_buff_addr];
    e_din <= m_mem[sd_buff_addr];
    if (cpu_we && m_idle && m_valid && !img_mounted) begin
      m_mem[cpu_addr]   <= cpu_wdata;
      m_known[cpu_addr] <= 1'b1;
    end
    if (sd_buff_wr && m_rdx) begin
      m_mem[sd_buff_addr]   <= sd_buff_dout;
      m_known[sd_buff_addr] <= 1'b1;
    end
  end

  always @(negedge clk_sys) begin
    if (cmp_en) begin
      if (k_rd)  chk(cpu_rdata === e_rd, "cpu_rdata", longint'(cpu_rdata), longint'(e_rd));
      if (k_din) chk(sd_buff_din === e_din, "sd_buff_din", longint'(sd_buff_din), longint'(e_din));
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic serve_rd(input logic [31:0] lba, input int abort_at);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    chk(sd_rd == 1'b0, "rd_drops_on_ack", longint'(sd_rd), 0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr   = 1'b1;
      sd_buff_addr = 9'(i);
      sd_buff_dout = disk[int'(lba)][i];
      m_rdx        = 1;
      if (i == abort_at) img_mounted = 1'b1;
      @(negedge clk_sys);
      if (i == abort_at) begin
        img_mounted = 1'b0;
        break;
      end
    end
    sd_buff_wr = 1'b0;
    m_rdx      = 0;
    sd_ack     = 1'b0;
  endtask

  task automatic serve_wb(input logic [31:0] lba);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    chk(sd_wr == 1'b0, "wr_drops_on_ack", longint'(sd_wr), 0);
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      @(negedge clk_sys);
      disk[int'(lba)][i] = sd_buff_din;
    end
    sd_ack = 1'b0;
  endtask

  // mode 0: normal host, 1: host never acks, 2: mount pulse mid read transfer.
  task automatic do_req(input bit is_load, input logic [31:0] lba, input int mode,
                        input bit with_wr, input logic [8:0] wa, input logic [7:0] wdv);
    bit e_err, e_wb, e_rdq, got_done, seen_wb, seen_rd;
    logic [31:0] wb_lba;
    int c, rd_hi;
    if (with_wr && m_valid) m_dirty = 1;
    e_err = 0; e_wb = 0; e_rdq = 0; wb_lba = m_lba;
    if (is_load) begin
      if (lba >= m_sectors) e_err = 1;
      else if (!(m_valid && lba == m_lba)) begin
        e_wb  = m_dirty;
        e_rdq = 1;
      end
    end else begin
      e_wb = m_dirty;
    end
    if (mode != 0) e_err = 1;
    req_load = is_load; req_flush = !is_load; req_lba = lba;
    cpu_we = with_wr; cpu_addr = wa; cpu_wdata = wdv;
    got_done = 0; seen_wb = 0; seen_rd = 0; rd_hi = 0; c = 0;
    while (!got_done && c < 3000) begin
      @(negedge clk_sys);
      c++;
      req_load = 1'b0; req_flush = 1'b0; cpu_we = 1'b0; m_idle = 0;
      if (sd_wr) begin
        chk(e_wb && !seen_wb, "wb_request", 1, longint'(e_wb));
        chk(sd_lba == wb_lba, "wb_lba", longint'(sd_lba), longint'(wb_lba));
        serve_wb(wb_lba);
        seen_wb = 1;
      end else if (sd_rd) begin
        if (mode == 1) rd_hi++;
        else begin
          chk(e_rdq && !seen_rd && (seen_wb == e_wb), "rd_request", 1, longint'(e_rdq));
          chk(sd_lba == lba, "rd_lba", longint'(sd_lba), longint'(lba));
          serve_rd(lba, (mode == 2) ? 100 : -1);
          seen_rd = 1;
          if (mode == 2) got_done = 1;
        end
      end else if (done) begin
        got_done = 1;
      end else begin
        chk(busy == 1'b1, "busy_during_req", longint'(busy), 1);
      end
    end
    chk(got_done && done, "done_seen", longint'(done), 1);
    chk(err == e_err, "err", longint'(err), longint'(e_err));
    chk(busy == 1'b0, "busy_at_done", longint'(busy), 0);
    chk(seen_wb == e_wb, "wb_happened", longint'(seen_wb), longint'(e_wb));
    if (mode == 1) chk(rd_hi >= 1019 && rd_hi <= 1027, "watchdog_len", rd_hi, 1023);
    else           chk(seen_rd == e_rdq, "rd_happened", longint'(seen_rd), longint'(e_rdq));
    if (!e_wb && !e_rdq && mode == 0) chk(c == 2, "done_latency", c, 2);
    if (e_wb) m_dirty = 0;
    if (mode == 2) begin
      m_valid = 0; m_dirty = 0; m_sectors = img_size >> 9;
    end else if (mode == 1) begin
      m_valid = 0;
    end else if (e_rdq) begin
      m_valid = 1; m_lba = lba; m_dirty = 0;
    end
    m_idle = 1;
  endtask

  task automatic mount(input logic [31:0] sz);
    img_size = sz; img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    m_sectors = sz >> 9; m_valid = 0; m_dirty = 0;
    @(negedge clk_sys);
    chk(done == 1'b0 && busy == 1'b0, "idle_mount_quiet", longint'(done), 0);
  endtask

  task automatic cpu_ops(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_addr  = 9'($urandom_range(0, 511));
      cpu_we    = ($urandom_range(0, 2) == 0);
      cpu_wdata = 8'($urandom);
      if (cpu_we && m_valid) m_dirty = 1;
      @(negedge clk_sys);
    end
    cpu_we = 1'b0;
  endtask

  initial begin
    logic [31:0] lba;
    int pick;
    for (int l = 0; l < 360; l++)
      for (int i = 0; i < 512; i++)
        disk[l][i] = (l == 5) ? 8'(i) : 8'($urandom);
    for (int i = 0; i < 512; i++) m_known[i] = 0;

    repeat (3) @(negedge clk_sys);
    chk(busy == 0 && done == 0 && err == 0, "reset_flags", {busy, done, err}, 0);
    chk(sd_rd == 0 && sd_wr == 0, "reset_sd_req", {sd_rd, sd_wr}, 0);
    chk(sd_lba == 32'd0, "reset_sd_lba", longint'(sd_lba), 0);
    chk(cpu_rdata == 8'd0, "reset_cpu_rdata", longint'(cpu_rdata), 0);
    chk(sd_buff_din == 8'd0, "reset_buff_din", longint'(sd_buff_din), 0);
    reset = 1'b0;
    @(negedge clk_sys);
    cmp_en = 1;

    // No image: everything is out of range.
    do_req(1, 32'd0, 0, 0, 9'd0, 8'd0);
    mount(32'h0002_D000);

    // Miss on lba 5, then pinned byte values.
    do_req(1, 32'd5, 0, 0, 9'd0, 8'd0);
    cpu_addr = 9'h101;
    @(negedge clk_sys);
    chk(cpu_rdata == 8'h01, "lba5_byte_101", longint'(cpu_rdata), 8'h01);
    cpu_addr = 9'h0FF;
    @(negedge clk_sys);
    chk(cpu_rdata == 8'hFF, "lba5_byte_0ff", longint'(cpu_rdata), 8'hFF);

    // Hit: no host traffic, done after 2 cycles.
    do_req(1, 32'd5, 0, 0, 9'd0, 8'd0);

    // Write in the request cycle must land in the write-back of lba 5.
    do_req(1, 32'd7, 0, 1, 9'd3, 8'hA5);
    chk(disk[5][3] == 8'hA5, "wb_byte3", longint'(disk[5][3]), 8'hA5);
    chk(m_valid && m_lba == 32'd7, "resident_lba7", longint'(m_lba), 7);

    // Boundary: last sector + 1.
    do_req(1, 32'd360, 0, 0, 9'd0, 8'd0);

    // Randomized traffic.
    for (int it = 0; it < 14; it++) begin
      cpu_ops($urandom_range(4, 24));
      pick = $urandom_range(0, 9);
      if (pick < 2)       do_req(0, 32'd0, 0, 0, 9'd0, 8'd0);
      else if (pick == 9) do_req(1, 32'(360 + $urandom_range(0, 40)), 0, 0, 9'd0, 8'd0);
      else begin
        lba = 32'($urandom_range(3, 10));
        do_req(1, lba, 0, ($urandom_range(0, 1) == 1), 9'($urandom_range(0, 511)), 8'($urandom));
      end
    end

    // Watchdog: clean the cache then let the host ignore a read.
    do_req(0, 32'd0, 0, 0, 9'd0, 8'd0);
    lba = (m_lba == 32'd11) ? 32'd12 : 32'd11;
    do_req(1, lba, 1, 0, 9'd0, 8'd0);

    // Mount pulse mid read transfer aborts; CPU writes are then ignored.
    do_req(1, 32'd20, 2, 0, 9'd0, 8'd0);
    cpu_addr = 9'h010; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    @(negedge clk_sys);
    cpu_we = 1'b0;
    @(negedge clk_sys);
    chk(cpu_rdata == disk[20][16], "write_ignored_after_abort", longint'(cpu_rdata), longint'(disk[20][16]));
    do_req(0, 32'd0, 0, 0, 9'd0, 8'd0);
    do_req(1, 32'd20, 0, 0, 9'd0, 8'd0);

    repeat (3) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
